// File: rtl/psg_pkg.sv
// Shared constants and width helpers for the PSG DAC output stage.
package psg_pkg;

    localparam int DEF_NUM_CHANNELS = 3;
    localparam int DEF_VOL_BITS     = 4;

    function automatic int therm_width(input int vol_bits);
        return (1 << vol_bits) - 1;
    endfunction

    function automatic int chan_width(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

endpackage

// File: rtl/psg_dac_lane.sv
// One DAC channel: active level register plus registered thermometer and PWM outputs.
// With PSG_DAC_SLEW_EN the active level ramps one step per period toward a target.
module psg_dac_lane
    import psg_pkg::*;
#(
    parameter  int VOL_BITS = DEF_VOL_BITS,
    localparam int THERM    = therm_width(VOL_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                wrap,
    input  logic                load,
    input  logic [VOL_BITS-1:0] load_level,
    input  logic [VOL_BITS-1:0] cnt,
    output logic [THERM-1:0]    dac,
    output logic                pwm
`ifdef PSG_DAC_SLEW_EN
    ,
    output logic                slewing
`endif
);

    logic [VOL_BITS-1:0] active;
    logic [THERM-1:0]    therm;

`ifdef PSG_DAC_SLEW_EN
    logic [VOL_BITS-1:0] target;
    logic [VOL_BITS-1:0] goal;

    // The loading wrap already steps toward the new level.
    assign goal = load ? load_level : target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
            target <= '0;
        end else if (wrap) begin
            if (load)
                target <= load_level;
            if (active < goal)
                active <= active + 1'b1;
            else if (active > goal)
                active <= active - 1'b1;
        end
    end

    assign slewing = (active != target);
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            active <= '0;
        else if (load)
            active <= load_level;
    end
`endif

    always_comb begin
        therm = '0;
        for (int i = 0; i < THERM; i++)
            therm[i] = (VOL_BITS'(i) < active);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac <= '0;
            pwm <= 1'b0;
        end else if (ena) begin
            dac <= therm;
            pwm <= (cnt < active);
        end
    end

endmodule

// File: rtl/psg_dac_channel_ctrl.sv
// PSG DAC channel controller: volume write port, shadow levels, period-aligned commit.
// Optional PSG_DAC_SLEW_EN adds per-channel ramping and the slewing output.
module psg_dac_channel_ctrl
    import psg_pkg::*;
#(
    parameter  int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter  int VOL_BITS     = DEF_VOL_BITS,
    localparam int THERM        = therm_width(VOL_BITS),
    localparam int CW           = chan_width(NUM_CHANNELS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          vol_valid,
    output logic                          vol_ready,
    input  logic [CW-1:0]                 vol_chan,
    input  logic [VOL_BITS-1:0]           vol_level,
    input  logic                          commit,
    output logic [NUM_CHANNELS*THERM-1:0] dac_ctrl,
    output logic [NUM_CHANNELS-1:0]       pwm_out,
    output logic                          period_start
`ifdef PSG_DAC_SLEW_EN
    ,
    output logic                          slewing
`endif
);

    logic [VOL_BITS-1:0] cnt;
    logic [VOL_BITS-1:0] shadow     [NUM_CHANNELS];
    logic [VOL_BITS-1:0] shadow_nxt [NUM_CHANNELS];
    logic                commit_pending;
    logic                write_fire;
    logic                wrap;
    logic                apply;

    assign vol_ready  = !commit_pending;
    assign write_fire = vol_valid && vol_ready;
    assign wrap       = ena && (cnt == VOL_BITS'(THERM - 1));
    assign apply      = wrap && (commit_pending || commit);

    // Lanes load from the next-state shadow so a write landing with the commit is included.
    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            shadow_nxt[k] = shadow[k];
            if (write_fire && (vol_chan == CW'(k)))
                shadow_nxt[k] = vol_level;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            commit_pending <= 1'b0;
            period_start   <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++)
                shadow[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++)
                shadow[k] <= shadow_nxt[k];
            period_start <= wrap;
            if (ena)
                cnt <= wrap ? '0 : cnt + 1'b1;
            if (apply)
                commit_pending <= 1'b0;
            else if (commit)
                commit_pending <= 1'b1;
        end
    end

`ifdef PSG_DAC_SLEW_EN
    logic [NUM_CHANNELS-1:0] lane_slew;
    assign slewing = |lane_slew;
`endif

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
        psg_dac_lane #(.VOL_BITS(VOL_BITS)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .ena        (ena),
            .wrap       (wrap),
            .load       (apply),
            .load_level (shadow_nxt[k]),
            .cnt        (cnt),
            .dac        (dac_ctrl[k*THERM +: THERM]),
            .pwm        (pwm_out[k])
`ifdef PSG_DAC_SLEW_EN
            ,
            .slewing    (lane_slew[k])
`endif
        );
    end

endmodule

// File: tb/tb_psg_dac_channel_ctrl.sv
// Scoreboard bench for psg_dac_channel_ctrl: expected per-period levels are queued by the
// stimulus and checked by a monitor over each PWM output window.
module tb_psg_dac_channel_ctrl;

    localparam int NCH = 3;
    localparam int VB  = 4;
    localparam int TH  = 15;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            ena       = 1'b1;
    logic            vol_valid = 1'b0;
    logic            commit    = 1'b0;
    logic [1:0]      vol_chan  = '0;
    logic [VB-1:0]   vol_level = '0;
    logic            vol_ready;
    logic            period_start;
    logic [NCH*TH-1:0] dac_ctrl;
    logic [NCH-1:0]  pwm_out;
`ifdef PSG_DAC_SLEW_EN
    logic            slewing;
`endif

    int checks   = 0;
    int failures = 0;
    logic [NCH*VB-1:0] exp_q[$];

    always #5 clk = ~clk;

    psg_dac_channel_ctrl #(.NUM_CHANNELS(NCH), .VOL_BITS(VB)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .vol_valid    (vol_valid),
        .vol_ready    (vol_ready),
        .vol_chan     (vol_chan),
        .vol_level    (vol_level),
        .commit       (commit),
        .dac_ctrl     (dac_ctrl),
        .pwm_out      (pwm_out),
        .period_start (period_start)
`ifdef PSG_DAC_SLEW_EN
        ,
        .slewing      (slewing)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int l0, input int l1, input int l2);
        exp_q.push_back({VB'(l2), VB'(l1), VB'(l0)});
    endtask

    task automatic wait_ps();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (period_start) return;
        end
        checks++;
        failures++;
        $display("FAIL period_start_timeout actual=none required=pulse_within_200_cycles");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic write(input int chan, input int lvl);
        vol_valid = 1'b1;
        vol_chan  = 2'(chan);
        vol_level = VB'(lvl);
        cyc(1);
        vol_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cyc(1);
        commit = 1'b0;
    endtask

    // Monitor: a window is the 15 freshly produced output cycles ending on a period_start.
    logic ena_q = 1'b0;
    int   win_len;
    int   pcnt [NCH];
    bit   synced;

    always @(posedge clk) ena_q <= ena;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            synced  = 1'b0;
            win_len = 0;
            for (int k = 0; k < NCH; k++) pcnt[k] = 0;
        end else begin
            if (ena_q) begin
                win_len++;
                for (int k = 0; k < NCH; k++)
                    if (pwm_out[k]) pcnt[k]++;
            end
            if (period_start) begin
                if (synced) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL window_unexpected actual=extra_window required=none");
                    end else begin
                        logic [NCH*VB-1:0] e;
                        e = exp_q.pop_front();
                        check("window_len", 64'(win_len), 64'(TH));
                        for (int k = 0; k < NCH; k++) begin
                            int lvl;
                            int th;
                            lvl = int'(e[k*VB +: VB]);
                            th  = (1 << lvl) - 1;
                            check($sformatf("dac_ch%0d", k), 64'(dac_ctrl[k*TH +: TH]), 64'(th));
                            check($sformatf("pwm_high_ch%0d", k), 64'(pcnt[k]), 64'(lvl));
                        end
                    end
                end
                synced  = 1'b1;
                win_len = 0;
                for (int k = 0; k < NCH; k++) pcnt[k] = 0;
            end
        end
    end

`ifndef PSG_DAC_SLEW_EN
    task automatic main_seq();
        int ps_seen;
        // P1: idle, then ch1=9 and commit
        wait_ps();
        push(0, 0, 0);
        write(1, 9);
        do_commit();
        check("ready_pending", 64'(vol_ready), 64'(0));
        // P2: ch1 applied; ch0=15 with commit in the same cycle, then a stalled write
        wait_ps();
        push(0, 9, 0);
        check("ready_after_wrap", 64'(vol_ready), 64'(1));
        vol_valid = 1'b1; vol_chan = 2'd0; vol_level = 4'd15; commit = 1'b1;
        cyc(1);
        commit = 1'b0; vol_level = 4'd3;
        for (int i = 0; i < 4; i++) begin
            check("ready_stall", 64'(vol_ready), 64'(0));
            cyc(1);
        end
        vol_valid = 1'b0;
        // P3: out-of-range channel write and commit
        wait_ps();
        push(15, 9, 0);
        check("ready_p3", 64'(vol_ready), 64'(1));
        write(3, 7);
        do_commit();
        check("ready_oob_pending", 64'(vol_ready), 64'(0));
        // P4: ch2=5 commit, then freeze for 40 cycles with the commit pending
        wait_ps();
        push(15, 9, 0);
        check("ready_oob_done", 64'(vol_ready), 64'(1));
        write(2, 5);
        do_commit();
        ena = 1'b0;
        ps_seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (period_start) ps_seen++;
        end
        check("no_period_start_frozen", 64'(ps_seen), 64'(0));
        check("ready_frozen_pending", 64'(vol_ready), 64'(0));
        ena = 1'b1;
        // P5: ch2=5 applied; write and commit while ena is low
        wait_ps();
        push(15, 9, 5);
        ena = 1'b0;
        cyc(1);
        check("ready_p5", 64'(vol_ready), 64'(1));
        write(2, 2);
        do_commit();
        cyc(5);
        ena = 1'b1;
        // P6: ch1=4 with the commit landing on the wrap cycle itself
        wait_ps();
        push(15, 9, 2);
        write(1, 4);
        cyc(13);
        commit = 1'b1;
        wait_ps();
        commit = 1'b0;
        // P7: wrap-cycle commit applied immediately
        push(15, 4, 2);
        check("ready_wrap_commit", 64'(vol_ready), 64'(1));
        wait_ps();
        cyc(1);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        // reset while a commit is pending
        vol_valid = 1'b1; vol_chan = 2'd0; vol_level = 4'd1; commit = 1'b1;
        cyc(1);
        vol_valid = 1'b0; commit = 1'b0;
        check("ready_before_rst", 64'(vol_ready), 64'(0));
        #2 rst = 1'b1;
        #1;
        check("rst_dac", 64'(dac_ctrl), 64'(0));
        check("rst_pwm", 64'(pwm_out), 64'(0));
        check("rst_ready", 64'(vol_ready), 64'(1));
        check("rst_period_start", 64'(period_start), 64'(0));
        cyc(1);
        rst = 1'b0;
        cyc(3);
    endtask
`else
    task automatic slew_seq();
        wait_ps();
        push(0, 0, 0);
        write(2, 4);
        do_commit();
        for (int p = 1; p <= 4; p++) begin
            wait_ps();
            push(0, 0, p);
            cyc(3);
            check($sformatf("slewing_p%0d", p + 1), 64'(slewing), 64'((p < 4) ? 1 : 0));
        end
        write(2, 0);
        do_commit();
        wait_ps();
        push(0, 0, 3);
        wait_ps();
        cyc(3);
        check("slewing_down", 64'(slewing), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_dac", 64'(dac_ctrl), 64'(0));
        check("rst_pwm", 64'(pwm_out), 64'(0));
        check("rst_slewing", 64'(slewing), 64'(0));
        check("rst_ready", 64'(vol_ready), 64'(1));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        cyc(1);
        rst = 1'b0;
        cyc(3);
    endtask
`endif

    initial begin
        cyc(2);
        check("reset_dac", 64'(dac_ctrl), 64'(0));
        check("reset_pwm", 64'(pwm_out), 64'(0));
        check("reset_ready", 64'(vol_ready), 64'(1));
        check("reset_period_start", 64'(period_start), 64'(0));
        rst = 1'b0;
`ifdef PSG_DAC_SLEW_EN
        slew_seq();
`else
        main_seq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
